pvr_vram_arb: RTL and testbench

- Shares the single PVR VRAM port between three masters: the region-array parser (RA), the ISP/TSP parameter fetcher (ISP) and the texture fetcher (TEX).
- Each master uses the existing VRAM handshake unchanged: it holds rd or wr high until it sees wait low, then watches valid for read data.
- The arbiter keeps one transaction in flight, arbitrates round-robin and routes the read-return strobe only to the owning master.
- It sits between the PVR front-end blocks and the VRAM controller.

---
 rtl/pvr_vram_arb_if.sv | 60 ++++++
 rtl/pvr_vram_arb.sv | 185 ++++++++++++++++++
 tb/tb_pvr_vram_arb.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pvr_vram_arb_if.sv
// Shared VRAM port bundle between the PVR front-end masters, the arbiter and the VRAM controller.
// Carries the three master request/return channels plus the single downstream VRAM channel.
// slave = the arbiter's view; master = the surrounding blocks (front-end masters and VRAM controller).
interface pvr_vram_arb_if;
  // Region-array parser
  logic        ra_rd;
  logic        ra_wr;
  logic [23:0] ra_addr;
  logic [31:0] ra_dout;
  logic        ra_wait;
  logic        ra_valid;
  // ISP/TSP parameter fetcher
  logic        isp_rd;
  logic        isp_wr;
  logic [23:0] isp_addr;
  logic [31:0] isp_dout;
  logic        isp_wait;
  logic        isp_valid;
  // Texture fetcher
  logic        tex_rd;
  logic        tex_wr;
  logic [23:0] tex_addr;
  logic [31:0] tex_dout;
  logic        tex_wait;
  logic        tex_valid;
  // Shared read data, qualified by the per-master valid
  logic [31:0] rd_data;
  // Downstream VRAM controller
  logic        vram_rd;
  logic        vram_wr;
  logic [23:0] vram_addr;
  logic [31:0] vram_dout;
  logic        vram_wait;
  logic        vram_valid;
  logic [31:0] vram_din;

  modport slave (
    input  ra_rd, ra_wr, ra_addr, ra_dout,
    output ra_wait, ra_valid,
    input  isp_rd, isp_wr, isp_addr, isp_dout,
    output isp_wait, isp_valid,
    input  tex_rd, tex_wr, tex_addr, tex_dout,
    output tex_wait, tex_valid,
    output rd_data,
    output vram_rd, vram_wr, vram_addr, vram_dout,
    input  vram_wait, vram_valid, vram_din
  );

  modport master (
    output ra_rd, ra_wr, ra_addr, ra_dout,
    input  ra_wait, ra_valid,
    output isp_rd, isp_wr, isp_addr, isp_dout,
    input  isp_wait, isp_valid,
    output tex_rd, tex_wr, tex_addr, tex_dout,
    input  tex_wait, tex_valid,
    input  rd_data,
    input  vram_rd, vram_wr, vram_addr, vram_dout,
    output vram_wait, vram_valid, vram_din
  );
endinterface

// File: rtl/pvr_vram_arb.sv
// Round-robin arbiter sharing one VRAM port between RA, ISP and TEX with one transaction in flight.
// Latency: request in IDLE drives vram_rd next cycle; read data pulses owner's valid the cycle after vram_valid.
// Backpressure: masters see combinational wait until the acceptance cycle; vram_wait holds the request in ISSUE.
module pvr_vram_arb #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 10
) (
  input  logic                clock,
  input  logic                reset_n,
  pvr_vram_arb_if.slave       bus,
  output logic [1:0]          owner,
  output logic                arb_err
);

  localparam logic [1:0] OWN_RA   = 2'd0;
  localparam logic [1:0] OWN_ISP  = 2'd1;
  localparam logic [1:0] OWN_TEX  = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        last_gnt;
  logic [TO_W-1:0]   to_cnt;
  // Set by reset: a read may have been in flight, so the first return seen
  // before any new read is accepted is swallowed instead of flagged as stray.
  logic              flush;

  logic [2:0]        req;
  logic [1:0]        gnt_idx;
  logic              gnt_vld;
  logic [23:0]       gnt_addr;
  logic [31:0]       gnt_dout;
  logic              gnt_rd;
  logic              accept;

  assign req[0] = bus.ra_rd  | bus.ra_wr;
  assign req[1] = bus.isp_rd | bus.isp_wr;
  assign req[2] = bus.tex_rd | bus.tex_wr;

  // The owner is released to its master only in the cycle VRAM takes the request.
  assign accept = (state == ISSUE) & ~bus.vram_wait;

  assign bus.ra_wait  = req[0] & ~(accept & (owner == OWN_RA));
  assign bus.isp_wait = req[1] & ~(accept & (owner == OWN_ISP));
  assign bus.tex_wait = req[2] & ~(accept & (owner == OWN_TEX));

  // Round-robin pick: search starts at the master after the last grant.
  always_comb begin
    gnt_idx = OWN_RA;
    gnt_vld = |req;
    unique case (last_gnt)
      OWN_RA: begin
        if (req[1])      gnt_idx = OWN_ISP;
        else if (req[2]) gnt_idx = OWN_TEX;
        else             gnt_idx = OWN_RA;
      end
      OWN_ISP: begin
        if (req[2])      gnt_idx = OWN_TEX;
        else if (req[0]) gnt_idx = OWN_RA;
        else             gnt_idx = OWN_ISP;
      end
      default: begin
        if (req[0])      gnt_idx = OWN_RA;
        else if (req[1]) gnt_idx = OWN_ISP;
        else             gnt_idx = OWN_TEX;
      end
    endcase
  end

  // Steer the winning master's address, data and direction (rd wins over wr).
  always_comb begin
    gnt_addr = bus.ra_addr;
    gnt_dout = bus.ra_dout;
    gnt_rd   = bus.ra_rd;
    unique case (gnt_idx)
      OWN_ISP: begin
        gnt_addr = bus.isp_addr;
        gnt_dout = bus.isp_dout;
        gnt_rd   = bus.isp_rd;
      end
      OWN_TEX: begin
        gnt_addr = bus.tex_addr;
        gnt_dout = bus.tex_dout;
        gnt_rd   = bus.tex_rd;
      end
      default: begin
        gnt_addr = bus.ra_addr;
        gnt_dout = bus.ra_dout;
        gnt_rd   = bus.ra_rd;
      end
    endcase
  end

  // Arbitration FSM with registered VRAM request, return routing and error tracking.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      last_gnt      <= OWN_TEX;
      to_cnt        <= '0;
      flush         <= 1'b1;
      arb_err       <= 1'b0;
      bus.vram_rd   <= 1'b0;
      bus.vram_wr   <= 1'b0;
      bus.vram_addr <= '0;
      bus.vram_dout <= '0;
      bus.rd_data   <= '0;
      bus.ra_valid  <= 1'b0;
      bus.isp_valid <= 1'b0;
      bus.tex_valid <= 1'b0;
    end else begin
      bus.ra_valid  <= 1'b0;
      bus.isp_valid <= 1'b0;
      bus.tex_valid <= 1'b0;

      // A return while nothing is outstanding is never routed.
      if (bus.vram_valid && (state != WAIT_DATA)) begin
        if (flush) flush   <= 1'b0;
        else       arb_err <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            owner         <= gnt_idx;
            last_gnt      <= gnt_idx;
            bus.vram_addr <= gnt_addr;
            bus.vram_dout <= gnt_dout;
            bus.vram_rd   <= gnt_rd;
            bus.vram_wr   <= ~gnt_rd;
            state         <= ISSUE;
          end else begin
            owner <= OWN_NONE;
          end
        end

        ISSUE: begin
          if (!bus.vram_wait) begin
            bus.vram_rd <= 1'b0;
            bus.vram_wr <= 1'b0;
            flush       <= 1'b0;
            if (bus.vram_rd) begin
              to_cnt <= '0;
              state  <= WAIT_DATA;
            end else begin
              owner <= OWN_NONE;
              state <= IDLE;
            end
          end
        end

        WAIT_DATA: begin
          if (bus.vram_valid) begin
            bus.rd_data <= bus.vram_din;
            unique case (owner)
              OWN_RA:  bus.ra_valid  <= 1'b1;
              OWN_ISP: bus.isp_valid <= 1'b1;
              OWN_TEX: bus.tex_valid <= 1'b1;
              default: ;
            endcase
            owner <= OWN_NONE;
            state <= IDLE;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            arb_err <= 1'b1;
            owner   <= OWN_NONE;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pvr_vram_arb.sv
// Directed bench for pvr_vram_arb built with a 16-cycle read timeout.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Each comparison is an immediate assertion that counts and reports failures.
module tb_pvr_vram_arb;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] owner;
  logic       arb_err;
  int         tests = 0;
  int         fails = 0;

  pvr_vram_arb_if bus ();

  pvr_vram_arb #(.TIMEOUT(16), .TO_W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .owner   (owner),
    .arb_err (arb_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_valids(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, bus.tex_valid, bus.isp_valid, bus.ra_valid}, {29'd0, exp});
  endtask

  logic [1:0]  rr_exp [6];
  logic [23:0] rr_addr [3];

  initial begin
    bus.ra_rd = 0;  bus.ra_wr = 0;  bus.ra_addr = '0;  bus.ra_dout = '0;
    bus.isp_rd = 0; bus.isp_wr = 0; bus.isp_addr = '0; bus.isp_dout = '0;
    bus.tex_rd = 0; bus.tex_wr = 0; bus.tex_addr = '0; bus.tex_dout = '0;
    bus.vram_wait = 0; bus.vram_valid = 0; bus.vram_din = '0;
    step(); step();
    reset_n = 1'b1;

    // Reset state
    chk("rst_owner", owner, 3);
    chk("rst_vram_rd", bus.vram_rd, 0);
    chk("rst_vram_wr", bus.vram_wr, 0);
    chk("rst_vram_addr", bus.vram_addr, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_err", arb_err, 0);
    chk_valids("rst_valids", 3'b000);

    // Single RA read
    bus.ra_rd = 1; bus.ra_addr = 24'h000100;
    #1 chk("rd1_wait_idle", bus.ra_wait, 1);
    step();
    chk("rd1_owner", owner, 0);
    chk("rd1_vram_rd", bus.vram_rd, 1);
    chk("rd1_addr", bus.vram_addr, 24'h000100);
    chk("rd1_wait_accept", bus.ra_wait, 0);
    bus.ra_rd = 0;
    step();
    chk("rd1_vram_rd_drop", bus.vram_rd, 0);
    step();
    bus.vram_valid = 1; bus.vram_din = 32'hDEADBEEF;
    #1 chk_valids("rd1_no_early_valid", 3'b000);
    step();
    bus.vram_valid = 0;
    chk_valids("rd1_valid", 3'b001);
    chk("rd1_data", bus.rd_data, 32'hDEADBEEF);
    chk("rd1_owner_free", owner, 3);
    step();
    chk_valids("rd1_valid_once", 3'b000);

    // Continuous reads from all three; last grant was RA so ISP leads
    rr_exp[0] = 1; rr_exp[1] = 2; rr_exp[2] = 0;
    rr_exp[3] = 1; rr_exp[4] = 2; rr_exp[5] = 0;
    rr_addr[0] = 24'h000010; rr_addr[1] = 24'h000020; rr_addr[2] = 24'h000030;
    bus.ra_rd = 1;  bus.ra_addr = rr_addr[0];
    bus.isp_rd = 1; bus.isp_addr = rr_addr[1];
    bus.tex_rd = 1; bus.tex_addr = rr_addr[2];
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_owner", owner, rr_exp[k]);
      chk("rr_addr", bus.vram_addr, rr_addr[rr_exp[k]]);
      chk("rr_waits", {29'd0, bus.tex_wait, bus.isp_wait, bus.ra_wait},
          {29'd0, 3'b111 & ~(3'b001 << rr_exp[k])});
      step();
      bus.vram_valid = 1; bus.vram_din = 32'hA000_0000 + k;
      step();
      bus.vram_valid = 0;
      chk_valids("rr_valid", 3'b001 << rr_exp[k]);
      chk("rr_data", bus.rd_data, 32'hA000_0000 + k);
    end
    bus.ra_rd = 0; bus.isp_rd = 0; bus.tex_rd = 0;
    step();
    chk("rr_idle_owner", owner, 3);

    // ISP write held off by vram_wait for 5 cycles
    bus.vram_wait = 1;
    bus.isp_wr = 1; bus.isp_addr = 24'h200000; bus.isp_dout = 32'h12345678;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("wr_isp_wait", bus.isp_wait, 1);
      chk("wr_vram_wr", bus.vram_wr, 1);
      chk("wr_addr", bus.vram_addr, 24'h200000);
      chk("wr_dout", bus.vram_dout, 32'h12345678);
      chk_valids("wr_no_valid", 3'b000);
      step();
    end
    bus.vram_wait = 0;
    #1 chk("wr_accept_wait", bus.isp_wait, 0);
    bus.isp_wr = 0;
    step();
    chk("wr_done_owner", owner, 3);
    chk("wr_done_vram_wr", bus.vram_wr, 0);
    step();
    chk_valids("wr_no_valid_after", 3'b000);

    // RA read times out after 16 WAIT_DATA cycles; pending TEX then served
    bus.ra_rd = 1; bus.ra_addr = 24'h000040;
    step();
    chk("to_owner", owner, 0);
    bus.ra_rd = 0;
    bus.tex_rd = 1; bus.tex_addr = 24'h300000;
    step();
    for (int i = 0; i < 15; i++) begin
      chk("to_err_early", arb_err, 0);
      step();
    end
    chk("to_err_last_cycle", arb_err, 0);
    step();
    chk("to_err_set", arb_err, 1);
    chk("to_owner_free", owner, 3);
    chk_valids("to_no_valid", 3'b000);
    step();
    chk("to_tex_owner", owner, 2);
    chk("to_tex_addr", bus.vram_addr, 24'h300000);
    chk("to_tex_wait", bus.tex_wait, 0);
    bus.tex_rd = 0;
    step();
    bus.vram_valid = 1; bus.vram_din = 32'hCAFEF00D;
    step();
    bus.vram_valid = 0;
    chk_valids("to_tex_valid", 3'b100);
    chk("to_tex_data", bus.rd_data, 32'hCAFEF00D);
    step();

    // Reset during WAIT_DATA, late return must be dropped silently
    bus.ra_rd = 1; bus.ra_addr = 24'h000080;
    step();
    bus.ra_rd = 0;
    step();
    reset_n = 0;
    step();
    chk("mr_owner", owner, 3);
    chk("mr_vram_rd", bus.vram_rd, 0);
    chk("mr_vram_addr", bus.vram_addr, 0);
    chk("mr_rd_data", bus.rd_data, 0);
    chk("mr_err", arb_err, 0);
    chk_valids("mr_valids", 3'b000);
    reset_n = 1;
    bus.vram_valid = 1; bus.vram_din = 32'h00BADBAD;
    bus.ra_rd = 1; bus.isp_rd = 1; bus.tex_rd = 1;
    bus.ra_addr = 24'h000500;
    step();
    bus.vram_valid = 0;
    chk("mr_late_err", arb_err, 0);
    chk("mr_late_data", bus.rd_data, 0);
    chk("mr_first_grant", owner, 0);
    bus.ra_rd = 0; bus.isp_rd = 0; bus.tex_rd = 0;
    step();
    bus.vram_valid = 1; bus.vram_din = 32'h11223344;
    step();
    bus.vram_valid = 0;
    chk_valids("mr_ra_valid", 3'b001);
    chk("mr_ra_data", bus.rd_data, 32'h11223344);
    step();

    // Stray vram_valid in IDLE
    bus.vram_valid = 1; bus.vram_din = 32'h55555555;
    step();
    bus.vram_valid = 0;
    chk("stray_err", arb_err, 1);
    chk_valids("stray_no_valid", 3'b000);
    chk("stray_data_kept", bus.rd_data, 32'h11223344);
    step();
    chk("stray_err_sticky", arb_err, 1);
    chk_valids("stray_no_valid_late", 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
